// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the key-schedule blocks:
// word width, FSM state codes, AES-256 round constants, S-box and RotWord.
package aes_pkg;

    localparam int WORD_LEN = 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SUB_A = 2'd1;
    localparam logic [1:0] SUB_B = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam logic [31:0] RCON_TABLE [7] = '{
        32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000,
        32'h10000000, 32'h20000000, 32'h40000000
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] rotword(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

endpackage

// File: rtl/gen_prev_subkey_if.sv
// Request/response bundle for the inverse key-schedule step, plus a debug view of its FSM state.
interface gen_prev_subkey_if #(
    parameter int KEY_LEN = 256
);
    // Handshake: a request transfers on a rising edge where valid_in & ready_in; anything
    // offered while ready_in is low is dropped. valid_out is a one-cycle pulse with no
    // backpressure; data_out then holds until the next result is written.
    logic [31:0]        Rcon;
    logic [KEY_LEN-1:0] data_in;
    logic               valid_in;
    logic               ready_in;
    logic [KEY_LEN-1:0] data_out;
    logic               valid_out;
    logic [1:0]         state;

    modport master (
        output Rcon, data_in, valid_in,
        input  ready_in, data_out, valid_out, state
    );

    modport slave (
        input  Rcon, data_in, valid_in,
        output ready_in, data_out, valid_out, state
    );

endinterface

// File: rtl/aes_sbox_word.sv
// Four parallel S-box lookups on a 32-bit word (SubWord); purely combinational.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub_word
);

    assign sub_word = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/gen_prev_subkey.sv
// Inverse AES-256 key-schedule step: recovers {w[i-8]..w[i-1]} from {w[i]..w[i+7]}
// over four clocks, sharing one SubWord unit between the two substitutions.
module gen_prev_subkey #(
    parameter int KEY_LEN  = 256,
    parameter int WORD_LEN = 32
) (
    input logic              clk,
    input logic              reset,
    gen_prev_subkey_if.slave bus
);
    import aes_pkg::*;

    if (KEY_LEN != 256 || WORD_LEN != aes_pkg::WORD_LEN) begin : g_bad_params
        $error("gen_prev_subkey: only KEY_LEN=256 and WORD_LEN=32 are supported");
    end

    logic [1:0]         state;
    logic [KEY_LEN-1:0] key_r;
    logic [31:0]        rcon_r;
    logic [31:0]        sub_lo_r;
    logic [KEY_LEN-1:0] data_out_r;
    logic               ready_r;
    logic               valid_r;

    logic [31:0]        w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0]        t;
    logic [31:0]        sbox_sel;
    logic [31:0]        sbox_result;
    logic               accept;
    logic [KEY_LEN-1:0] result;

    // w0 is w[i], w7 is w[i+7]
    assign {w0, w1, w2, w3, w4, w5, w6, w7} = key_r;
    assign t = w7 ^ w6;

    assign sbox_sel = (state == SUB_A) ? w3 : rotword(t);

    aes_sbox_word u_sbox (
        .word     (sbox_sel),
        .sub_word (sbox_result)
    );

    // ready_r lags the return to IDLE by one clock, so acceptance needs both
    assign accept = (state == IDLE) && ready_r && bus.valid_in;

    assign result = {w0 ^ sbox_result ^ rcon_r,
                     w1 ^ w0, w2 ^ w1, w3 ^ w2,
                     w4 ^ sub_lo_r,
                     w5 ^ w4, w6 ^ w5, t};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
            data_out_r <= '0;
            key_r      <= '0;
            rcon_r     <= '0;
            sub_lo_r   <= '0;
        end else begin
            valid_r <= (state == OUT);
            ready_r <= (state == IDLE) && !accept;
            case (state)
                IDLE: begin
                    if (accept) begin
                        key_r  <= bus.data_in;
                        rcon_r <= bus.Rcon;
                        state  <= SUB_A;
                    end
                end
                SUB_A: begin
                    sub_lo_r <= sbox_result;
                    state    <= SUB_B;
                end
                SUB_B: begin
                    data_out_r <= result;
                    state      <= OUT;
                end
                OUT:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_in  = ready_r;
    assign bus.valid_out = valid_r;
    assign bus.data_out  = data_out_r;
    assign bus.state     = state;

endmodule

// File: tb/tb_gen_prev_subkey.sv
// Bench for gen_prev_subkey: vector table, hand-written timing/reset sequences and a
// random round-trip against an independent forward key-expansion model.
module tb_gen_prev_subkey;

    logic clk;
    logic reset;

    gen_prev_subkey_if #(.KEY_LEN(256)) bus();

    gen_prev_subkey #(.KEY_LEN(256), .WORD_LEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_pushed     = 0;
    int n_pulses     = 0;
    logic prev_vo    = 1'b0;
    logic [255:0] exp_q[$];

    logic [7:0] sbox_m [256];

    typedef struct {
        logic [255:0] din;
        logic [31:0]  rcon;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // S-box built from its definition: GF(2^8) inverse followed by the affine map
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            b = b >> 1;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, r, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv; r = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_m[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [255:0] fwd_step(input logic [255:0] p, input logic [31:0] r);
        logic [31:0] q [8];
        logic [31:0] f [8];
        for (int j = 0; j < 8; j++) q[j] = p[255-32*j -: 32];
        f[0] = q[0] ^ subword_m({q[7][23:0], q[7][31:24]}) ^ r;
        for (int j = 1; j < 4; j++) f[j] = q[j] ^ f[j-1];
        f[4] = q[4] ^ subword_m(f[3]);
        for (int j = 5; j < 8; j++) f[j] = q[j] ^ f[j-1];
        return {f[0], f[1], f[2], f[3], f[4], f[5], f[6], f[7]};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Caller sits at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [255:0] key, input logic [31:0] r, input logic [255:0] exp);
        int waited;
        waited = 0;
        while (bus.ready_in !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.ready_in !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_ready_timeout: got ready_in=%b expected 1", bus.ready_in);
            return;
        end
        bus.data_in  = key;
        bus.Rcon     = r;
        bus.valid_in = 1'b1;
        exp_q.push_back(exp);
        n_pushed++;
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || bus.ready_in !== 1'b1) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0 || bus.ready_in !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
        end
    endtask

    // Scoreboard: every valid_out pulse pops one expected pair
    initial begin
        forever begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) begin
                n_pulses++;
                check("valid_out_width", 256'(prev_vo), 256'd0);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_valid_out: got a pulse with data %h expected none", bus.data_out);
                end else begin
                    check("data_out", bus.data_out, exp_q.pop_front());
                end
            end
            prev_vo = bus.valid_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] p, k, sched [8];
        logic [31:0]  r;

        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.Rcon     = '0;
        build_sbox();

        vecs[0] = '{256'h9ba354118e6925afa51a8b5f2067fcdea8b09c1a93d194cdbe49846eb75d5b9a, 32'h01000000,
                    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4};
        vecs[1] = '{256'h0, 32'h0,
                    256'h63636363_00000000_00000000_00000000_63636363_00000000_00000000_00000000};
        p = rand256();       vecs[2] = '{fwd_step(p, 32'h02000000), 32'h02000000, p};
        p = rand256();       vecs[3] = '{fwd_step(p, 32'h0), 32'h0, p};
        p = {256{1'b1}};     vecs[4] = '{fwd_step(p, 32'h40000000), 32'h40000000, p};
        p = rand256();       vecs[5] = '{fwd_step(p, 32'h1b000000), 32'h1b000000, p};

        repeat (2) @(negedge clk);
        check("reset_ready_in", 256'(bus.ready_in), 256'd1);
        check("reset_valid_out", 256'(bus.valid_out), 256'd0);
        check("reset_data_out", bus.data_out, 256'd0);
        check("reset_state", 256'(bus.state), 256'(aes_pkg::IDLE));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].din, vecs[i].rcon, vecs[i].exp);
            drain();
        end

        // Latency: pulse appears exactly after the third edge past acceptance
        bus.data_in = vecs[0].din; bus.Rcon = vecs[0].rcon; bus.valid_in = 1'b1;
        exp_q.push_back(vecs[0].exp);
        n_pushed++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
            check($sformatf("latency_valid_out_edge%0d", c), 256'(bus.valid_out), 256'(c == 3));
        end
        drain();

        // Busy-drop: request held for four edges with a new key each cycle
        p = rand256(); r = 32'h08000000; k = fwd_step(p, r);
        bus.data_in = k; bus.Rcon = r; bus.valid_in = 1'b1;
        exp_q.push_back(p);
        n_pushed++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("busy_ready_edge%0d", c), 256'(bus.ready_in), 256'd0);
            if (c < 3) begin
                bus.data_in = rand256();
                bus.Rcon    = $urandom();
            end else begin
                bus.valid_in = 1'b0;
            end
        end
        @(negedge clk);
        check("busy_ready_edge4", 256'(bus.ready_in), 256'd1);
        drain();

        // Reset two edges after acceptance discards the request
        bus.data_in = rand256(); bus.Rcon = 32'h01000000; bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midop_data_out", bus.data_out, 256'd0);
        check("midop_ready_in", 256'(bus.ready_in), 256'd1);
        check("midop_valid_out", 256'(bus.valid_out), 256'd0);
        check("midop_state", 256'(bus.state), 256'(aes_pkg::IDLE));
        repeat (6) @(negedge clk);
        p = rand256(); r = 32'h20000000;
        send(fwd_step(p, r), r, p);
        drain();

        // Reset and request on the same edge: nothing is accepted
        reset = 1'b1; bus.valid_in = 1'b1; bus.data_in = rand256(); bus.Rcon = 32'h04000000;
        @(negedge clk);
        reset = 1'b0; bus.valid_in = 1'b0;
        check("rst_valid_ready_in", 256'(bus.ready_in), 256'd1);
        check("rst_valid_state", 256'(bus.state), 256'(aes_pkg::IDLE));
        check("rst_valid_data_out", bus.data_out, 256'd0);
        repeat (6) @(negedge clk);

        // Full walk back from the last pair of the forward schedule
        sched[0] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        for (int n = 1; n < 8; n++) sched[n] = fwd_step(sched[n-1], 32'h01000000 << (n - 1));
        for (int n = 7; n >= 1; n--) begin
            send(sched[n], 32'h01000000 << (n - 1), sched[n-1]);
            drain();
        end

        // Random round-trip, back to back
        for (int i = 0; i < 1000; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            r = (sel == 7) ? 32'h0 : (32'h01000000 << sel);
            p = rand256();
            send(fwd_step(p, r), r, p);
        end
        drain();

        check("pulse_count", 256'(n_pulses), 256'(n_pushed));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
